imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//   Boot-time program loader: the write side of the instruction memory the core fetches from.
//   Accepts a big-endian byte stream (valid/ready) and packs 4 bytes per 32-bit word.
//   Writes each word to instruction memory at word-aligned byte addresses.
//   Holds the core in reset (cpu_resetN low) until the load completes.
// PARAMETERS
//   DEPTH      256    instruction memory size in 32-bit words; max loadable length
//   CNT_W      9      width of num_words / word counter; must hold DEPTH
//   BASE_ADDR  32'h0  byte address of the first word written
// PORTS
//   clk         in   1      system clock, all logic on rising edge
//   resetN      in   1      synchronous, active-low reset
//   start       in   1      1-cycle pulse; begins a load (ignored while busy)
//   num_words   in   CNT_W  words to load; sampled on accepted start
//   byte_valid  in   1      byte_data valid
//   byte_data   in   8      stream byte, first byte of a word = bits [31:24]
//   byte_ready  out  1      loader can take a byte this cycle
//   mem_we      out  1      instruction memory write strobe, 1 cycle per word
//   mem_addr    out  32     byte address, BASE_ADDR + 4*word_index
//   mem_wdata   out  32     assembled word
//   cpu_resetN  out  1      active-low core reset; low except in DONE
//   busy        out  1      load in progress
//   done        out  1      load finished OK; held until next start or reset
//   error       out  1      load rejected/failed; held until next start or reset
// BEHAVIOUR
//   - All outputs registered. Reset value 0 for every output (cpu_resetN=0 keeps core held).
//   - Byte transfer occurs only on a cycle with byte_valid && byte_ready.
//   - FSM states: IDLE, LOAD, WRITE, CHECK (CHECKSUM_EN only), DONE, ERR.
//   - IDLE: byte_ready=0. On start:
//     - num_words==0 or >DEPTH -> ERR.
//     - otherwise -> LOAD. Latch num_words; clear word_index, byte_index, word buffer.
//   - LOAD: byte_ready=1, busy=1.
//     - Each transfer shifts the byte into the buffer; byte_index increments 0..3.
//     - Transfer with byte_index==3 -> WRITE.
//   - WRITE (1 cycle): byte_ready=0, mem_we=1, mem_addr/mem_wdata hold the word.
//     - Word whose 4th byte is accepted in cycle N is written in cycle N+1.
//     - Throughput is 1 word per 5 cycles at best.
//     - Next state: word_index+1 < num_words -> LOAD (index++);
//       else CHECK if CHECKSUM_EN, else DONE.
//   - DONE: done=1, busy=0, cpu_resetN=1 starting the first DONE cycle.
//   - ERR: error=1, busy=0, cpu_resetN=0.
//   - start in DONE or ERR restarts as in IDLE:
//     - cpu_resetN drops, done/error clear on the next cycle.
//   - start while busy is ignored. byte_valid outside LOAD/CHECK is ignored and not consumed.
//   - mem_addr arithmetic is 32-bit, word_index<<2 + BASE_ADDR. No wrap:
//     - index is bounded by num_words-1 <= DEPTH-1.
//   - Stream stall (byte_valid low) waits indefinitely in LOAD; no timeout.
//   - resetN low mid-load: next edge -> IDLE, all outputs 0.
//     - Already-written words are not undone; the partial word is discarded.
// CONFIGURATION
//   CHECKSUM_EN defined:
//     - After the last WRITE, enter CHECK with byte_ready=1 and accept one extra byte.
//     - If the byte equals the XOR of all data bytes -> DONE, else -> ERR.
//   CHECKSUM_EN undefined: no CHECK state. The last WRITE goes directly to DONE.
// TESTING
//   1. num_words=2, bytes 3C 01 10 01 / 8C 22 00 04:
//      -> writes 3C011001@0x0, then 8C220004@0x4; done=1, cpu_resetN=1.
//   2. Same stream with byte_valid toggled every other cycle:
//      -> identical writes; each mem_we exactly 1 cycle after the 4th byte.
//   3. start with num_words=0, and separately with num_words=DEPTH+1:
//      -> error=1 next cycle, no mem_we, cpu_resetN=0.
//   4. resetN low after 6 bytes of a 3-word load:
//      -> one write only, then all outputs 0.
//      Restart loads 3 words cleanly from 0x0.
//   5. start pulsed mid-load:
//      -> ignored. After DONE, start again -> cpu_resetN low, reload succeeds.
//   6. CHECKSUM_EN, words 00000001 00000002:
//      - checksum byte 03 -> done=1.
//      - checksum byte 00 -> error=1, cpu_resetN stays 0.

Source files
------------

// File: rtl/imem_loader.sv
// ============================================================================
// Module   : imem_loader
// Function : Boot loader that packs a big-endian byte stream into 32-bit words
//            and writes them to instruction memory while holding the core in
//            reset. Optional macro CHECKSUM_EN adds a trailing XOR check byte.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_loader #(
  parameter int          DEPTH     = 256,
  parameter int          CNT_W     = 9,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             start,
  input  logic [CNT_W-1:0] num_words,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             cpu_resetN,
  output logic             busy,
  output logic             done,
  output logic             error
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WRITE = 3'd2,
`ifdef CHECKSUM_EN
    S_CHECK = 3'd3,
`endif
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] num_words_q, num_words_d;
  logic [CNT_W-1:0] word_idx_q, word_idx_d;
  logic [1:0]       byte_idx_q, byte_idx_d;
  logic [23:0]      word_q, word_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;
  logic             byte_ready_q, byte_ready_d;
  logic             mem_we_q, mem_we_d;
  logic             cpu_resetN_q, cpu_resetN_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
`ifdef CHECKSUM_EN
  logic [7:0]       csum_q, csum_d;
`endif
  logic             w_xfer;

  assign w_xfer = byte_valid && byte_ready_q;

  always_comb begin
    state_d     = state_q;
    num_words_d = num_words_q;
    word_idx_d  = word_idx_q;
    byte_idx_d  = byte_idx_q;
    word_d      = word_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef CHECKSUM_EN
    csum_d      = csum_q;
`endif

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          if ((num_words == '0) || (num_words > CNT_W'(DEPTH))) begin
            state_d = S_ERR;
          end else begin
            state_d     = S_LOAD;
            num_words_d = num_words;
            word_idx_d  = '0;
            byte_idx_d  = '0;
            word_d      = '0;
`ifdef CHECKSUM_EN
            csum_d      = '0;
`endif
          end
        end
      end
      S_LOAD: begin
        if (w_xfer) begin
          word_d     = {word_q[15:0], byte_data};
          byte_idx_d = byte_idx_q + 2'd1;
`ifdef CHECKSUM_EN
          csum_d     = csum_q ^ byte_data;
`endif
          // Memory-side registers are loaded here so the word appears with mem_we
          if (byte_idx_q == 2'd3) begin
            state_d     = S_WRITE;
            mem_wdata_d = {word_q, byte_data};
            mem_addr_d  = BASE_ADDR + (32'(word_idx_q) << 2);
          end
        end
      end
      S_WRITE: begin
        if ((word_idx_q + CNT_W'(1)) < num_words_q) begin
          state_d    = S_LOAD;
          word_idx_d = word_idx_q + CNT_W'(1);
        end else begin
`ifdef CHECKSUM_EN
          state_d = S_CHECK;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef CHECKSUM_EN
      S_CHECK: begin
        if (w_xfer) begin
          state_d = (byte_data == csum_q) ? S_DONE : S_ERR;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so every port is a flop
    byte_ready_d = (state_d == S_LOAD);
`ifdef CHECKSUM_EN
    if (state_d == S_CHECK) byte_ready_d = 1'b1;
`endif
    mem_we_d     = (state_d == S_WRITE);
    busy_d       = byte_ready_d || mem_we_d;
    done_d       = (state_d == S_DONE);
    error_d      = (state_d == S_ERR);
    cpu_resetN_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q      <= S_IDLE;
      num_words_q  <= '0;
      word_idx_q   <= '0;
      byte_idx_q   <= '0;
      word_q       <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      byte_ready_q <= 1'b0;
      mem_we_q     <= 1'b0;
      cpu_resetN_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
`ifdef CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      num_words_q  <= num_words_d;
      word_idx_q   <= word_idx_d;
      byte_idx_q   <= byte_idx_d;
      word_q       <= word_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      byte_ready_q <= byte_ready_d;
      mem_we_q     <= mem_we_d;
      cpu_resetN_q <= cpu_resetN_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
`ifdef CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  assign byte_ready = byte_ready_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign cpu_resetN = cpu_resetN_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// Module   : tb_imem_loader
// Function : Directed self-checking bench for imem_loader with a write
//            scoreboard. Honours CHECKSUM_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_loader;

  localparam int CNT_W = 9;
  localparam int DEPTH = 256;

  logic             clk = 1'b0;
  logic             resetN;
  logic             start;
  logic [CNT_W-1:0] num_words;
  logic             byte_valid;
  logic [7:0]       byte_data;
  logic             byte_ready;
  logic             mem_we;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic             cpu_resetN;
  logic             busy;
  logic             done;
  logic             error;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;
  wr_t         exp_q[$];
  logic [31:0] wbuf[4];

  imem_loader #(.DEPTH(DEPTH), .CNT_W(CNT_W), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .resetN(resetN), .start(start), .num_words(num_words),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_resetN(cpu_resetN), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // Every write strobe must match the next queued word, one cycle each
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $error("FAIL unexpected_write addr=%h data=%h", mem_addr, mem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        assert (mem_addr === e.a && mem_wdata === e.d) else begin
          errors++;
          $error("FAIL write observed=%h@%h expected=%h@%h", mem_wdata, mem_addr, e.d, e.a);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input int n);
    num_words = CNT_W'(n);
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    repeat (gap) begin @(posedge clk); #1; end
    byte_valid = 1'b1;
    byte_data  = b;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (byte_ready === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $error("FAIL byte_ready_timeout observed=0 expected=1");
    end
    @(posedge clk); #1;
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] a, input logic [31:0] w, input int gap);
    exp_q.push_back('{a: a, d: w});
    for (int k = 0; k < 4; k++) send_byte(w[31-8*k -: 8], gap);
    @(negedge clk);
    chk("we_after_4th", {31'b0, mem_we}, 32'd1);
  endtask

  task automatic run_load(input int n, input int gap);
    logic [7:0] cs;
    cs = 8'h00;
    for (int i = 0; i < n; i++) begin
      send_word(32'(i) << 2, wbuf[i], gap);
      cs = cs ^ wbuf[i][31:24] ^ wbuf[i][23:16] ^ wbuf[i][15:8] ^ wbuf[i][7:0];
    end
`ifdef CHECKSUM_EN
    send_byte(cs, gap);
`endif
    @(negedge clk);
    chk("done", {31'b0, done}, 32'd1);
    chk("cpu_resetN_done", {31'b0, cpu_resetN}, 32'd1);
    chk("busy_done", {31'b0, busy}, 32'd0);
    chk("error_done", {31'b0, error}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk(tag, {24'b0, byte_ready, mem_we, cpu_resetN, busy, done, error, 2'b0}, 32'd0);
    chk({tag, "_addr"}, mem_addr, 32'd0);
    chk({tag, "_wdata"}, mem_wdata, 32'd0);
  endtask

  initial begin
    resetN = 1'b0; start = 1'b0; num_words = '0; byte_valid = 1'b0; byte_data = 8'h00;
    repeat (2) @(posedge clk); #1;
    resetN = 1'b1;
    @(negedge clk);
    check_all_zero("reset");

    // Two-word load, back-to-back bytes
    wbuf[0] = 32'h3C011001; wbuf[1] = 32'h8C220004;
    pulse_start(2);
    @(negedge clk);
    chk("busy_load", {31'b0, busy}, 32'd1);
    chk("ready_load", {31'b0, byte_ready}, 32'd1);
    run_load(2, 0);

    // Restart from DONE with a gap before every byte
    pulse_start(2);
    @(negedge clk);
    chk("cpu_resetN_restart", {31'b0, cpu_resetN}, 32'd0);
    chk("done_clear", {31'b0, done}, 32'd0);
    run_load(2, 1);

    // Invalid lengths
    pulse_start(0);
    @(negedge clk);
    chk("err_zero", {29'b0, error, cpu_resetN, busy}, 32'd4);
    pulse_start(DEPTH + 1);
    @(negedge clk);
    chk("err_over", {29'b0, error, cpu_resetN, busy}, 32'd4);
    chk("done_err", {31'b0, done}, 32'd0);

    // Reset after six bytes of a three-word load
    wbuf[0] = 32'h11223344; wbuf[1] = 32'h55667788; wbuf[2] = 32'h99AABBCC;
    pulse_start(3);
    send_word(32'h0, wbuf[0], 0);
    send_byte(8'h55, 0);
    send_byte(8'h66, 0);
    resetN = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check_all_zero("mid_reset");
    resetN = 1'b1;
    @(posedge clk); #1;
    pulse_start(3);
    run_load(3, 0);

    // Start mid-load is ignored; restart after DONE
    wbuf[0] = 32'hDEADBEEF; wbuf[1] = 32'h01234567;
    pulse_start(2);
    exp_q.push_back('{a: 32'h0, d: wbuf[0]});
    send_byte(8'hDE, 0);
    send_byte(8'hAD, 0);
    pulse_start(1);
    send_byte(8'hBE, 0);
    send_byte(8'hEF, 0);
    @(negedge clk);
    chk("we_ignored_start", {31'b0, mem_we}, 32'd1);
    send_word(32'h4, wbuf[1], 0);
`ifdef CHECKSUM_EN
    send_byte(8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF ^ 8'h01 ^ 8'h23 ^ 8'h45 ^ 8'h67, 0);
`endif
    @(negedge clk);
    chk("done_ignored_start", {31'b0, done}, 32'd1);
    wbuf[0] = 32'hCAFEF00D;
    pulse_start(1);
    @(negedge clk);
    chk("cpu_resetN_reload", {31'b0, cpu_resetN}, 32'd0);
    run_load(1, 0);

`ifdef CHECKSUM_EN
    wbuf[0] = 32'h00000001; wbuf[1] = 32'h00000002;
    pulse_start(2);
    run_load(2, 0);
    pulse_start(2);
    send_word(32'h0, wbuf[0], 0);
    send_word(32'h4, wbuf[1], 0);
    send_byte(8'h00, 0);
    @(negedge clk);
    chk("csum_bad_error", {30'b0, error, cpu_resetN}, 32'd2);
`endif

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
